xmem_port_arbiter: RTL and testbench

- Arbitrates a single port of a dual-port 2048x32 data memory between two requesters: the host (single-word accesses) and the DMA engine (bursts).
- One memory access is issued per cycle. Arbitration is round-robin, with the DMA holding a burst lock.
- Read data is steered back to the requester that issued the read.
- Sits between the host/DMA interconnect and one memory wrapper port; the other port stays dedicated to the datapath.

---
 rtl/xmem_port_arbiter.sv | 113 +++++++++++
 tb/tb_xmem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_port_arbiter.sv
// Round-robin arbiter for one port of the 2048x32 data memory: host single-word
// accesses vs. DMA bursts with a burst lock. Optional host anti-starvation: XMEM_ARB_STARVE_EN.
module xmem_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_last,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t  r_state;
  logic        r_last_dma;
  logic [1:0]  r_rd_owner;   // bit 0 = host, bit 1 = DMA

  logic w_locked;
  logic w_host_force;
  logic w_dma_sel;
  logic w_h_gnt;
  logic w_d_gnt;

  assign w_locked = (r_state == ST_LOCKED);

`ifdef XMEM_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;

  // Once the host has waited MAX_WAIT locked cycles it steals one slot from the burst.
  assign w_host_force = w_locked & h_req & (r_wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_h_gnt) begin
      r_wait_cnt <= '0;
    end else if (w_locked && h_req && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign w_host_force = 1'b0;
`endif

  // DMA takes the slot when it holds the lock, is alone, or it is its round-robin turn.
  assign w_dma_sel = d_req & ~w_host_force & (w_locked | ~h_req | ~r_last_dma);
  assign w_d_gnt   = ~rst & w_dma_sel;
  assign w_h_gnt   = ~rst & h_req & ~w_dma_sel;

  assign h_gnt     = w_h_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_h_gnt | w_d_gnt;
  assign mem_wr    = w_d_gnt ? d_wr    : (w_h_gnt & h_wr);
  assign mem_addr  = w_d_gnt ? d_addr  : h_addr;
  assign mem_wdata = w_d_gnt ? d_wdata : h_wdata;

  // Gating with rst drops a read return that collides with a reset cycle.
  assign h_rvalid  = r_rd_owner[0] & ~rst;
  assign d_rvalid  = r_rd_owner[1] & ~rst;
  assign h_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the same pre-edge values of the combinational grant logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OPEN;
      r_last_dma <= 1'b1;
      r_rd_owner <= 2'b00;
    end else begin
      r_rd_owner <= {w_d_gnt & ~d_wr, w_h_gnt & ~h_wr};

      if (w_d_gnt) begin
        r_last_dma <= 1'b1;
      end else if (w_h_gnt) begin
        r_last_dma <= 1'b0;
      end

      if (r_state == ST_OPEN) begin
        if (w_d_gnt && !d_last) r_state <= ST_LOCKED;
      end else begin
        // Burst ends on its last granted beat, or aborts when DMA withdraws its request.
        if (w_d_gnt ? d_last : !d_req) r_state <= ST_OPEN;
      end
    end
  end

endmodule

// File: tb/tb_xmem_port_arbiter.sv
// Self-checking bench for xmem_port_arbiter: directed scenarios with literal expectations,
// then randomized host/DMA traffic compared every cycle against a rule-level model.
module tb_xmem_port_arbiter;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 16;
`ifdef XMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              h_req = 1'b0, h_wr = 1'b0;
  logic [ADDR_W-1:0] h_addr = '0;
  logic [DATA_W-1:0] h_wdata = '0;
  logic              d_req = 1'b0, d_wr = 1'b0, d_last = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              h_gnt, h_rvalid, d_gnt, d_rvalid;
  logic [DATA_W-1:0] h_rdata, d_rdata;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  xmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_last(d_last),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Power-up contents of any word never written; address 5 holds a known pattern.
  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous-read memory behind the arbitrated port.
  logic [31:0] ram [2048];
  bit          ram_wr [2048];
  logic [31:0] ram_q = '0;

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_wr) ram_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
  end
  assign mem_rdata = ram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who may use the port this cycle, from the arbitration rules.
  bit          m_lock = 1'b0;
  bit          m_last_dma = 1'b1;
  bit          m_rd_host = 1'b0, m_rd_dma = 1'b0;
  logic [31:0] m_rd_data = '0;
  int          m_wait = 0;
  logic [31:0] m_mem [2048];
  bit          m_written [2048];

  always @(negedge clk) begin : compare
    int          win;   // 0 none, 1 host, 2 DMA
    bit          forced;
    logic [31:0] e_addr, e_wd;
    bit          e_wr;
    forced = STARVE_ON && m_lock && h_req && (m_wait >= MAX_WAIT);
    if (rst)                 win = 0;
    else if (forced)         win = 1;
    else if (m_lock && d_req) win = 2;
    else if (h_req && d_req) win = m_last_dma ? 1 : 2;
    else if (h_req)          win = 1;
    else if (d_req)          win = 2;
    else                     win = 0;
    e_wr   = (win == 1) ? h_wr : (win == 2) ? d_wr : 1'b0;
    e_addr = 32'((win == 2) ? d_addr : h_addr);
    e_wd   = (win == 2) ? d_wdata : h_wdata;

    check("h_gnt", h_gnt, (win == 1));
    check("d_gnt", d_gnt, (win == 2));
    check("mem_en", mem_en, (win != 0));
    check("mem_wr", mem_wr, e_wr);
    check("mem_addr", 32'(mem_addr), e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("h_rvalid", h_rvalid, m_rd_host && !rst);
    check("d_rvalid", d_rvalid, m_rd_dma && !rst);
    if (m_rd_host && !rst) check("h_rdata", h_rdata, m_rd_data);
    if (m_rd_dma && !rst)  check("d_rdata", d_rdata, m_rd_data);

    if (rst) begin
      m_lock = 1'b0; m_last_dma = 1'b1; m_rd_host = 1'b0; m_rd_dma = 1'b0; m_wait = 0;
    end else begin
      m_rd_host = (win == 1) && !h_wr;
      m_rd_dma  = (win == 2) && !d_wr;
      if (win != 0 && !e_wr) m_rd_data = m_written[e_addr] ? m_mem[e_addr] : init_val(int'(e_addr));
      if (win != 0 && e_wr) begin
        m_mem[e_addr]     = e_wd;
        m_written[e_addr] = 1'b1;
      end
      if (win == 1) m_wait = 0;
      else if (m_lock && h_req && m_wait < MAX_WAIT) m_wait++;
      if (win == 2) m_lock = !d_last;
      else if (m_lock && !d_req) m_lock = 1'b0;
      if (win == 1) m_last_dma = 1'b0;
      else if (win == 2) m_last_dma = 1'b1;
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; h_req = 1'b0; d_req = 1'b0; d_last = 1'b0;
    drive_edge();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got stuck expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic hg, dg, dropped;
    int host_c, beats, beats_after, burst_left;

    drive_edge();
    drive_edge();
    // Requests are ignored while reset is held.
    h_req = 1'b1; h_wr = 1'b0; h_addr = 11'h005;
    sample_edge();
    check("rst_h_gnt", h_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rvalid", {h_rvalid, d_rvalid}, 0);
    drive_edge();
    rst = 1'b0;

    // Host read alone.
    sample_edge();
    check("hrd_gnt", h_gnt, 1);
    check("hrd_d_gnt", d_gnt, 0);
    drive_edge();
    h_req = 1'b0;
    sample_edge();
    check("hrd_rvalid", h_rvalid, 1);
    check("hrd_rdata", h_rdata, 32'hDEAD_BEEF);
    check("hrd_d_rvalid", d_rvalid, 0);
    drive_edge();

    // Contention from reset: H, D, H, D with rvalid one cycle behind.
    do_reset();
    h_req = 1'b1; h_wr = 1'b0; h_addr = 11'h003;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 11'h009; d_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_edge();
      check("rr_h_gnt", h_gnt, (i % 2 == 0));
      check("rr_d_gnt", d_gnt, (i % 2 == 1));
      if (i > 0) check("rr_h_rvalid", h_rvalid, (i % 2 == 1));
      drive_edge();
    end
    h_req = 1'b0; d_req = 1'b0;
    sample_edge();
    check("rr_d_rvalid_tail", d_rvalid, 1);
    drive_edge();

    // Four-beat DMA write burst holds off a requesting host.
    do_reset();
    h_req = 1'b1; h_wr = 1'b1; h_addr = 11'h010; h_wdata = 32'h1234_5678;
    sample_edge();
    check("bl_pre_h_gnt", h_gnt, 1);
    drive_edge();
    h_wr = 1'b0; h_addr = 11'h020;
    d_req = 1'b1; d_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_addr = 11'(11'h100 + k); d_wdata = 32'hA000_0000 + k; d_last = (k == 3);
      sample_edge();
      check("bl_d_gnt", d_gnt, 1);
      check("bl_h_held", h_gnt, 0);
      drive_edge();
    end
    d_addr = 11'h104; d_wdata = 32'hA000_0004; d_last = 1'b1;
    sample_edge();
    check("bl_h_after", h_gnt, 1);
    check("bl_d_after", d_gnt, 0);
    drive_edge();
    h_req = 1'b0;
    sample_edge();
    check("bl_d_next", d_gnt, 1);
    drive_edge();
    d_req = 1'b0; d_last = 1'b0;
    for (int k = 0; k < 4; k++) check("bl_mem", ram[11'h100 + k], 32'hA000_0000 + k);

    // Burst abort after two beats: host granted in the abort cycle.
    do_reset();
    h_req = 1'b1; h_wr = 1'b1; h_addr = 11'h011; h_wdata = 32'h0BAD_F00D;
    sample_edge();
    check("ab_pre_h_gnt", h_gnt, 1);
    drive_edge();
    h_wr = 1'b0; h_addr = 11'h012;
    d_req = 1'b1; d_wr = 1'b1; d_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_addr = 11'(11'h200 + k); d_wdata = 32'hB000_0000 + k;
      sample_edge();
      check("ab_d_gnt", d_gnt, 1);
      drive_edge();
    end
    d_req = 1'b0;
    sample_edge();
    check("ab_h_gnt", h_gnt, 1);
    drive_edge();
    h_req = 1'b0;

    // Reset right after a granted DMA read.
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 11'h007; d_last = 1'b0;
    sample_edge();
    check("rm_d_gnt", d_gnt, 1);
    drive_edge();
    rst = 1'b1; d_req = 1'b0;
    sample_edge();
    check("rm_d_rvalid", d_rvalid, 0);
    drive_edge();
    rst = 1'b0;
    h_req = 1'b1; h_wr = 1'b0; h_addr = 11'h001;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 11'h008; d_last = 1'b1;
    sample_edge();
    check("rm_h_first", h_gnt, 1);
    check("rm_d_first", d_gnt, 0);
    drive_edge();
    h_req = 1'b0;
    sample_edge();
    check("rm_d_second", d_gnt, 1);
    drive_edge();
    d_req = 1'b0; d_last = 1'b0;

    // 40-beat burst with the host waiting from the burst's second cycle.
    do_reset();
    h_req = 1'b1; h_wr = 1'b1; h_addr = 11'h030; h_wdata = 32'h0000_0030;
    sample_edge();
    drive_edge();
    h_req = 1'b0;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 11'h300; d_wdata = 32'hC000_0000; d_last = 1'b0;
    beats = 0; host_c = 0; beats_after = 0;
    for (int c = 1; c <= 60 && (beats < 40 || host_c == 0); c++) begin
      if (c == 2) begin
        h_req = 1'b1; h_wr = 1'b0; h_addr = 11'h031;
      end
      sample_edge();
      hg = h_gnt; dg = d_gnt;
      if (hg) host_c = c;
      if (dg) begin
        beats++;
        if (host_c != 0) beats_after++;
      end
      drive_edge();
      if (hg) h_req = 1'b0;
      if (dg) begin
        if (beats == 40) begin
          d_req = 1'b0; d_last = 1'b0;
        end else begin
          d_addr = d_addr + 11'd1; d_wdata = d_wdata + 32'd1; d_last = (beats == 39);
        end
      end
    end
    check("sv_host_cycle", host_c, STARVE_ON ? 18 : 41);
    check("sv_beats_after", beats_after, STARVE_ON ? 23 : 0);
    check("sv_beats_total", beats, 40);
    h_req = 1'b0; d_req = 1'b0;

    // Random traffic obeying the hold-until-grant protocol.
    burst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      sample_edge();
      hg = h_gnt; dg = d_gnt;
      drive_edge();
      dropped = 1'b0;
      if (rst) rst = 1'b0;
      if (h_req && hg) h_req = 1'b0;
      if (d_req && dg) begin
        burst_left--;
        if (burst_left == 0 || $urandom_range(0, 99) < 4) begin
          d_req = 1'b0; d_last = 1'b0; burst_left = 0; dropped = 1'b1;
        end else begin
          d_addr = d_addr + 11'd1; d_wdata = $urandom; d_last = (burst_left == 1);
        end
      end
      if (!h_req && $urandom_range(0, 99) < 60) begin
        h_req = 1'b1; h_wr = 1'($urandom_range(0, 1));
        h_addr = 11'($urandom_range(0, 31)); h_wdata = $urandom;
      end
      if (!d_req && !dropped && $urandom_range(0, 99) < 30) begin
        burst_left = $urandom_range(1, 24);
        d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
        d_addr = 11'($urandom_range(0, 31)); d_wdata = $urandom; d_last = (burst_left == 1);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; h_req = 1'b0; d_req = 1'b0; d_last = 1'b0; burst_left = 0;
      end
    end
    rst = 1'b0; h_req = 1'b0; d_req = 1'b0;
    repeat (3) drive_edge();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
